// File: rtl/matmul_load_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// matmul_load_sequencer_pkg
// Shared constants and FSM state encoding for the matmul load sequencer.
//   DWIDTH/EXPONENT/MANTISSA : fp16 element format
//   MAT_MUL_SIZE / ROW_ELEMS : elements packed into one BRAM row
//   ROWS                     : rows per matrix (A, then B)
//   AWIDTH                   : BRAM address width
//   WR_LAT                   : cycles from addr_pi to the matching write strobe
// ---------------------------------------------------------------------------
package matmul_load_sequencer_pkg;

    localparam int DWIDTH       = 16;
    localparam int EXPONENT     = 5;
    localparam int MANTISSA     = 10;
    localparam int MAT_MUL_SIZE = 32;
    localparam int ROW_ELEMS    = MAT_MUL_SIZE;
    localparam int ROWS         = 32;
    localparam int AWIDTH       = 7;
    localparam int WR_LAT       = 2;
    localparam int ROW_BITS     = ROW_ELEMS * DWIDTH;

    // DRAIN starts in the cycle the last B row is issued on addr_pi. Its strobe
    // lands WR_LAT cycles later; the remaining cycles keep the RAM write port
    // quiet so start_mat_mul rises three cycles after the final we_b.
    localparam int DRAIN_CYCLES = WR_LAT + 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL_A = 3'd1,
        ST_FILL_B = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RUN    = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

endpackage

// File: rtl/matmul_load_sequencer_row_packer.sv
// ---------------------------------------------------------------------------
// matmul_load_sequencer_row_packer
// Packs ROW_ELEMS consecutive stream elements into one BRAM row.
//   clk, reset     : clock, asynchronous active-low reset
//   i_clear        : synchronous clear of counter and row
//   i_valid        : element accepted this cycle
//   i_data         : element value
//   o_last_accept  : combinational, the accepted element completes the row
//   o_row_full     : 1-cycle pulse, o_row_data holds a complete row
//   o_row_data     : packed row, element k at [k*DWIDTH +: DWIDTH]
// ---------------------------------------------------------------------------
module matmul_load_sequencer_row_packer
    import matmul_load_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_valid,
    input  logic [DWIDTH-1:0]   i_data,
    output logic                o_last_accept,
    output logic                o_row_full,
    output logic [ROW_BITS-1:0] o_row_data
);

    localparam int            CW       = $clog2(ROW_ELEMS);
    localparam logic [CW-1:0] LAST_IDX = CW'(ROW_ELEMS - 1);

    logic [CW-1:0]     r_elem_cnt;
    logic              r_row_full;
    logic [DWIDTH-1:0] r_elem [ROW_ELEMS];
    logic              w_last;

    assign w_last        = i_valid && (r_elem_cnt == LAST_IDX);
    assign o_last_accept = w_last;
    assign o_row_full    = r_row_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_elem_cnt <= '0;
            r_row_full <= 1'b0;
        end else if (i_clear) begin
            r_elem_cnt <= '0;
            r_row_full <= 1'b0;
        end else begin
            r_row_full <= w_last;
            if (i_valid) begin
                r_elem_cnt <= w_last ? '0 : r_elem_cnt + 1'b1;
            end
        end
    end

    // One register per element slot. A completed row is cleared in its
    // row_full cycle, but slot 0 may already take the next row's first
    // element in that same cycle, so the write has priority over the clear.
    generate
        for (genvar gi = 0; gi < ROW_ELEMS; gi++) begin : g_elem
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_elem[gi] <= '0;
                end else if (i_clear) begin
                    r_elem[gi] <= '0;
                end else if (i_valid && (r_elem_cnt == CW'(gi))) begin
                    r_elem[gi] <= i_data;
                end else if (r_row_full) begin
                    r_elem[gi] <= '0;
                end
            end
            assign o_row_data[gi*DWIDTH +: DWIDTH] = r_elem[gi];
        end
    endgenerate

endmodule

// File: rtl/matmul_load_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_load_sequencer
// Feeds the fp16 32x32 matmul wrapper: packs a valid/ready element stream
// into 32 rows of matrix A then 32 rows of matrix B, writes them through
// addr_pi/data_pi/we_a/we_b, then holds start_mat_mul until done_mat_mul.
//   clk, reset             : clock, asynchronous active-low reset
//   cmd_go                 : 1-cycle pulse starting an operation (IDLE only)
//   s_valid/s_ready/s_data : element stream, row-major, A first then B
//   enable_writing_to_mem  : address-mux select for the A/B write path
//   addr_pi                : row address, WR_LAT cycles ahead of the strobe
//   data_pi                : packed row, held between strobes
//   we_a, we_b             : single-cycle write strobes
//   start_mat_mul          : level, high throughout RUN
//   done_mat_mul           : completion from the matmul core
//   busy                   : high outside IDLE
//   op_done                : 1-cycle pulse at the end of an operation
// ---------------------------------------------------------------------------
module matmul_load_sequencer
    import matmul_load_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_go,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DWIDTH-1:0]   s_data,
    output logic                enable_writing_to_mem,
    output logic [AWIDTH-1:0]   addr_pi,
    output logic [ROW_BITS-1:0] data_pi,
    output logic                we_a,
    output logic                we_b,
    output logic                start_mat_mul,
    input  logic                done_mat_mul,
    output logic                busy,
    output logic                op_done
);

    localparam int            RW         = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [2:0]    DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_drain_cnt;

    logic                w_fill;
    logic                w_accept;
    logic                w_last_accept;
    logic                w_last_row;
    logic                w_row_full;
    logic                w_clear;
    logic [ROW_BITS-1:0] w_row_data;

    logic [RW-1:0]       r_row_idx;
    logic [AWIDTH-1:0]   r_addr_pi;
    logic [ROW_BITS-1:0] r_row_hold;
    logic [ROW_BITS-1:0] r_data_pi;
    logic                r_we_a;
    logic                r_we_b;
    logic                r_pipe_vld [WR_LAT];
    logic                r_pipe_sel [WR_LAT];

    assign w_fill     = (r_state == ST_FILL_A) || (r_state == ST_FILL_B);
    assign w_accept   = s_valid && w_fill;
    assign w_last_row = w_last_accept && (r_row_idx == LAST_ROW);
    assign w_clear    = (r_state == ST_IDLE);

    assign addr_pi = r_addr_pi;
    assign data_pi = r_data_pi;
    assign we_a    = r_we_a;
    assign we_b    = r_we_b;

    matmul_load_sequencer_row_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_clear),
        .i_valid       (w_accept),
        .i_data        (s_data),
        .o_last_accept (w_last_accept),
        .o_row_full    (w_row_full),
        .o_row_data    (w_row_data)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 1'b1 : '0;
        end
    end

    // The FILL states advance on the edge that accepts the last element of
    // the 32nd row, so the row-issue cycle already shows the next state:
    // s_ready stays high across the A->B boundary and drops right after B.
    always_comb begin
        w_state_next          = r_state;
        s_ready               = 1'b0;
        enable_writing_to_mem = 1'b0;
        start_mat_mul         = 1'b0;
        busy                  = 1'b1;
        op_done               = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (cmd_go) w_state_next = ST_FILL_A;
            end
            ST_FILL_A: begin
                s_ready               = 1'b1;
                enable_writing_to_mem = 1'b1;
                if (w_last_row) w_state_next = ST_FILL_B;
            end
            ST_FILL_B: begin
                s_ready               = 1'b1;
                enable_writing_to_mem = 1'b1;
                if (w_last_row) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                enable_writing_to_mem = 1'b1;
                if (r_drain_cnt == DRAIN_LAST) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                start_mat_mul = 1'b1;
                if (done_mat_mul) w_state_next = ST_FIN;
            end
            ST_FIN: begin
                op_done      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- row index / address issue ----------------
    // The index wraps to 0 on the 32nd row, so B restarts at row 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_idx <= '0;
            r_addr_pi <= '0;
        end else if (w_clear) begin
            r_row_idx <= '0;
        end else if (w_last_accept) begin
            r_addr_pi <= AWIDTH'(r_row_idx);
            r_row_idx <= w_last_row ? '0 : r_row_idx + 1'b1;
        end
    end

    // ---------------- write pipeline ----------------
    // Stage 0 is loaded together with addr_pi; the strobe registers sample
    // the last stage, giving exactly WR_LAT cycles between address and
    // strobe. The packed row is parked in r_row_hold during its row_full
    // cycle because the packer starts clearing it for the next row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_vld[0] <= 1'b0;
            r_pipe_sel[0] <= 1'b0;
            r_row_hold    <= '0;
            r_data_pi     <= '0;
            r_we_a        <= 1'b0;
            r_we_b        <= 1'b0;
        end else begin
            r_pipe_vld[0] <= w_last_accept;
            r_pipe_sel[0] <= (r_state == ST_FILL_B);
            if (w_row_full) begin
                r_row_hold <= w_row_data;
            end
            r_we_a <= r_pipe_vld[WR_LAT-1] && !r_pipe_sel[WR_LAT-1];
            r_we_b <= r_pipe_vld[WR_LAT-1] &&  r_pipe_sel[WR_LAT-1];
            if (r_pipe_vld[WR_LAT-1]) begin
                r_data_pi <= r_row_hold;
            end
        end
    end

    generate
        for (genvar gi = 1; gi < WR_LAT; gi++) begin : g_pipe
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_pipe_vld[gi] <= 1'b0;
                    r_pipe_sel[gi] <= 1'b0;
                end else begin
                    r_pipe_vld[gi] <= r_pipe_vld[gi-1];
                    r_pipe_sel[gi] <= r_pipe_sel[gi-1];
                end
            end
        end
    endgenerate

endmodule
